// File: rtl/dpd_pkg.sv
// Shared DPD datapath helpers: accumulator sizing and the common
// round / arithmetic-shift / saturate arithmetic used by every output stage.
package dpd_pkg;

    // Wide enough for any accumulator + rounding bit in the DPD chain.
    localparam int CALC_W = 64;

    typedef struct packed {
        logic                     sat;
        logic signed [CALC_W-1:0] val;
    } rss_t;

    function automatic int wacc(input int wi, input int nmax);
        return wi + $clog2(nmax) + 1;
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_max(input int wo);
        return (CALC_W'(1) <<< (wo - 1)) - CALC_W'(1);
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_min(input int wo);
        return -(CALC_W'(1) <<< (wo - 1));
    endfunction

    // Round half toward +inf, shift right arithmetically, clamp to wo bits.
    function automatic rss_t round_shift_sat(input logic signed [CALC_W-1:0] x,
                                             input int shift, input int wo);
        logic signed [CALC_W-1:0] r;
        rss_t                     res;
        r = x;
        if (shift > 0) begin
            r = (x + (CALC_W'(1) <<< (shift - 1))) >>> shift;
        end
        res.sat = 1'b0;
        res.val = r;
        if (r > sat_max(wo)) begin
            res.sat = 1'b1;
            res.val = sat_max(wo);
        end else if (r < sat_min(wo)) begin
            res.sat = 1'b1;
            res.val = sat_min(wo);
        end
        return res;
    endfunction

endpackage

// File: rtl/prod_accum_round_sat.sv
// Combinational round + shift + saturate from a WR-bit signed sum to a
// WO-bit signed sample with a saturation flag.
module round_sat
    import dpd_pkg::*;
#(
    parameter int WR    = 26,
    parameter int WO    = 20,
    parameter int SHIFT = 4
) (
    input  logic signed [WR-1:0] din,
    output logic signed [WO-1:0] dout,
    output logic                 sat
);

    rss_t                    res;
    logic [CALC_W-WO-1:0]    res_hi_unused;

    always_comb res = round_shift_sat(CALC_W'(din), SHIFT, WO);

    // After clamping, the upper bits are pure sign extension.
    assign {res_hi_unused, dout} = res.val;
    assign sat                   = res.sat;

endmodule

// File: rtl/prod_accum.sv
// Sums a framed burst of signed multiplier products into one rounded,
// shifted and saturated output sample per frame.
module prod_accum
    import dpd_pkg::*;
#(
    parameter int WI    = 20,
    parameter int WO    = 20,
    parameter int NMAX  = 16,
    parameter int SHIFT = 4
) (
    input  logic                   clk,
    input  logic                   reset_b,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic signed [WI-1:0]   in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    output logic signed [WO-1:0]   out_data,
    output logic                   out_sat,
    output logic                   err,
    output logic [$clog2(NMAX):0]  term_cnt
);

    localparam int WACC = wacc(WI, NMAX);
    localparam int CW   = $clog2(NMAX) + 1;

    localparam logic [0:0] ST_IDLE  = 1'b1;
    localparam logic [0:0] ST_ACCUM = 1'b0;

    logic signed [WACC-1:0] acc_q, acc_d, sum_next, in_ext;
    logic [CW-1:0]          term_cnt_q, term_cnt_d;
    logic [0:0]             first_q, first_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_sat_q, out_sat_d;
    logic                   err_q, err_d;
    logic signed [WO-1:0]   out_data_q, out_data_d, rs_data;
    logic                   rs_sat, dump, fire;

    assign in_ext   = {{(WACC-WI){in_data[WI-1]}}, in_data};
    // A new frame never sees the previous frame's acc, even back-to-back.
    assign sum_next = ((first_q == ST_IDLE) ? WACC'(0) : acc_q) + in_ext;
    assign dump     = in_valid && !in_last && (term_cnt_q == CW'(NMAX - 1));
    assign fire     = in_valid && (in_last || dump);

    round_sat #(
        .WR    (WACC + 1),
        .WO    (WO),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .din  ({sum_next[WACC-1], sum_next}),
        .dout (rs_data),
        .sat  (rs_sat)
    );

    always_comb begin
        // NOTE: every _d gets a hold/default value first so no path leaves it unassigned (no latch).
        acc_d       = acc_q;
        term_cnt_d  = term_cnt_q;
        first_d     = first_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (clr) begin
            acc_d      = '0;
            term_cnt_d = '0;
            first_d    = ST_IDLE;
            err_d      = 1'b0;
        end else if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = rs_data;
            out_sat_d   = rs_sat;
            first_d     = ST_IDLE;
            term_cnt_d  = '0;
            if (dump) begin
                err_d = 1'b1;
            end
        end else if (in_valid) begin
            acc_d      = sum_next;
            term_cnt_d = term_cnt_q + CW'(1);
            first_d    = ST_ACCUM;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            acc_q       <= '0;
            term_cnt_q  <= '0;
            first_q     <= ST_IDLE;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            term_cnt_q  <= term_cnt_d;
            first_q     <= first_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign err       = err_q;
    assign term_cnt  = term_cnt_q;

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum: two instances (SHIFT=4 and SHIFT=0)
// share stimulus and are compared every cycle against a frame-level model.
module tb_prod_accum;

    localparam int WI   = 20;
    localparam int WO   = 20;
    localparam int NMAX = 16;
    localparam int CW   = $clog2(NMAX) + 1;
    localparam int SH_A = 4;
    localparam int SH_B = 0;
    localparam int VW   = 2 * (WO + 3 + CW);

    typedef logic [VW-1:0] vec_t;

    logic                 clk = 1'b0;
    logic                 reset_b;
    logic                 clr;
    logic                 in_valid;
    logic signed [WI-1:0] in_data;
    logic                 in_last;

    logic                 ov_a, os_a, er_a, ov_b, os_b, er_b;
    logic signed [WO-1:0] od_a, od_b;
    logic [CW-1:0]        tc_a, tc_b;

    prod_accum #(.WI(WI), .WO(WO), .NMAX(NMAX), .SHIFT(SH_A)) dut_a (
        .clk(clk), .reset_b(reset_b), .clr(clr), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .out_valid(ov_a),
        .out_data(od_a), .out_sat(os_a), .err(er_a), .term_cnt(tc_a)
    );

    prod_accum #(.WI(WI), .WO(WO), .NMAX(NMAX), .SHIFT(SH_B)) dut_b (
        .clk(clk), .reset_b(reset_b), .clr(clr), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .out_valid(ov_b),
        .out_data(od_b), .out_sat(os_b), .err(er_b), .term_cnt(tc_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the terms of the open frame, plus last emitted results.
    longint q[$];
    logic   m_valid;
    logic   m_err;
    longint m_data [2];
    logic   m_sat  [2];

    function automatic longint round_ref(longint s, int sh);
        longint d, v;
        if (sh == 0) return s;
        d = longint'(1) << sh;
        v = s + d / 2;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_err   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_data[k] = 0;
            m_sat[k]  = 1'b0;
        end
    endtask

    task automatic model_emit();
        longint sum, r, hi, lo;
        sum = 0;
        foreach (q[i]) sum += q[i];
        hi = (longint'(1) << (WO - 1)) - 1;
        lo = -(longint'(1) << (WO - 1));
        for (int k = 0; k < 2; k++) begin
            r = round_ref(sum, (k == 0) ? SH_A : SH_B);
            m_sat[k]  = (r > hi) || (r < lo);
            m_data[k] = (r > hi) ? hi : ((r < lo) ? lo : r);
        end
        m_valid = 1'b1;
        q.delete();
    endtask

    function automatic vec_t expected();
        logic [WO-1:0] da, db;
        logic [CW-1:0] c;
        longint        ta, tb;
        ta = m_data[0];
        tb = m_data[1];
        da = ta[WO-1:0];
        db = tb[WO-1:0];
        c  = CW'(q.size());
        return {m_valid, da, m_sat[0], m_err, c, m_valid, db, m_sat[1], m_err, c};
    endfunction

    function automatic vec_t observed();
        return {ov_a, od_a, os_a, er_a, tc_a, ov_b, od_b, os_b, er_b, tc_b};
    endfunction

    // Drive one cycle of inputs, let the DUTs clock it, advance the model.
    task automatic step(input logic v, input int d, input logic l, input logic c);
        logic signed [WI-1:0] dv;
        @(negedge clk);
        dv       = WI'(d);
        in_valid = v;
        in_data  = dv;
        in_last  = l;
        clr      = c;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        if (c) begin
            q.delete();
            m_err = 1'b0;
        end else if (v) begin
            q.push_back(longint'(dv));
            if (l || q.size() == NMAX) begin
                if (!l) m_err = 1'b1;
                model_emit();
            end
        end
    endtask

    task automatic test_reset();
        vec_t obs, exp;
        model_reset();
        #1;
        obs = observed(); exp = expected(); n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL reset_state: got %h want %h", obs, exp);
        end
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    task automatic test_single_term();
        vec_t obs, exp;
        step(1, 40, 1, 0);
        obs = observed(); exp = expected(); n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL single_term: got %h want %h", obs, exp);
        end
        n_cmp++;
        if (od_a !== WO'(3) || ov_a !== 1'b1) begin
            n_bad++; $display("FAIL single_term_const: got valid=%b data=%0d want valid=1 data=3", ov_a, od_a);
        end
        step(0, 0, 0, 0);
        obs = observed(); exp = expected(); n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL single_term_pulse: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_gaps();
        vec_t obs, exp;
        int   terms [4] = '{100, -20, 7, 1};
        for (int i = 0; i < 4; i++) begin
            step(1, terms[i], (i == 3), 0);
            obs = observed(); exp = expected(); n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL gaps_beat%0d: got %h want %h", i, obs, exp);
            end
            if (i == 3) begin
                n_cmp++;
                if (od_a !== WO'(6)) begin
                    n_bad++; $display("FAIL gaps_const: got %0d want 6", od_a);
                end
            end
            for (int g = 0; g < 2; g++) begin
                step(0, 0, 0, 0);
                obs = observed(); exp = expected(); n_cmp++;
                if (obs !== exp) begin
                    n_bad++; $display("FAIL gaps_idle%0d_%0d: got %h want %h", i, g, obs, exp);
                end
            end
        end
    endtask

    task automatic test_round_neg();
        vec_t obs, exp;
        int   vals [2] = '{-24, -25};
        int   want [2] = '{-1, -2};
        for (int i = 0; i < 2; i++) begin
            step(1, vals[i], 1, 0);
            obs = observed(); exp = expected(); n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL round_neg%0d: got %h want %h", i, obs, exp);
            end
            n_cmp++;
            if (od_a !== WO'(want[i])) begin
                n_bad++; $display("FAIL round_neg_const%0d: got %0d want %0d", i, od_a, want[i]);
            end
        end
    endtask

    task automatic test_saturation();
        vec_t obs, exp;
        int   vals [2] = '{524287, -524288};
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NMAX; i++) begin
                step(1, vals[s], (i == NMAX - 1), 0);
                obs = observed(); exp = expected(); n_cmp++;
                if (obs !== exp) begin
                    n_bad++; $display("FAIL sat%0d_beat%0d: got %h want %h", s, i, obs, exp);
                end
            end
            n_cmp++;
            if (od_b !== WO'(vals[s]) || os_b !== 1'b1) begin
                n_bad++; $display("FAIL sat%0d_const: got data=%0d sat=%b want data=%0d sat=1", s, od_b, os_b, vals[s]);
            end
        end
    endtask

    task automatic test_overrun();
        vec_t obs, exp;
        for (int i = 0; i < NMAX + 1; i++) begin
            step(1, 16, 0, 0);
            obs = observed(); exp = expected(); n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL overrun_beat%0d: got %h want %h", i, obs, exp);
            end
            if (i == NMAX - 1) begin
                n_cmp++;
                if (ov_a !== 1'b1 || od_a !== WO'(16) || er_a !== 1'b1) begin
                    n_bad++; $display("FAIL overrun_const: got valid=%b data=%0d err=%b want 1/16/1", ov_a, od_a, er_a);
                end
            end
        end
        step(1, 2, 1, 0);
        obs = observed(); exp = expected(); n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL overrun_close: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        vec_t obs, exp;
        int   vals [2] = '{5, 3};
        for (int i = 0; i < 2; i++) begin
            step(1, vals[i], 1, 0);
            obs = observed(); exp = expected(); n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL b2b%0d: got %h want %h", i, obs, exp);
            end
            n_cmp++;
            if (ov_b !== 1'b1 || od_b !== WO'(vals[i])) begin
                n_bad++; $display("FAIL b2b_const%0d: got valid=%b data=%0d want 1/%0d", i, ov_b, od_b, vals[i]);
            end
        end
    endtask

    task automatic test_clr();
        vec_t obs, exp;
        step(1, 1000, 0, 0);
        step(1, 2000, 0, 0);
        step(1, 99, 1, 1);
        obs = observed(); exp = expected(); n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL clr_midframe: got %h want %h", obs, exp);
        end
        n_cmp++;
        if (ov_b !== 1'b0 || er_b !== 1'b0 || tc_b !== '0) begin
            n_bad++; $display("FAIL clr_const: got valid=%b err=%b cnt=%0d want 0/0/0", ov_b, er_b, tc_b);
        end
        step(1, 7, 1, 0);
        obs = observed(); exp = expected(); n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL clr_after: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_reset_mid();
        vec_t obs, exp;
        step(1, 300, 0, 0);
        step(1, 400, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset_b = 1'b0;
        #1;
        model_reset();
        obs = observed(); exp = expected(); n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL reset_mid_async: got %h want %h", obs, exp);
        end
        @(negedge clk);
        reset_b = 1'b1;
        step(1, 8, 1, 0);
        obs = observed(); exp = expected(); n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL reset_mid_next: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_random();
        vec_t obs, exp;
        logic v, l, c;
        int   d;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom % 4) != 0;
            l = ($urandom % 5) == 0;
            c = ($urandom % 80) == 0;
            d = ($urandom % 2) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
            step(v, d, l, c);
            obs = observed(); exp = expected(); n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL random_cyc%0d: got %h want %h", i, obs, exp);
            end
        end
    endtask

    initial begin
        reset_b  = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        test_reset();
        test_single_term();
        test_gaps();
        test_round_neg();
        test_saturation();
        test_overrun();
        test_back_to_back();
        test_clr();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Accumulates the stream of signed products from the DPD multiplier stage into one output sample per input sample.
- A framed burst of basis-term products, delimited by in_last, is summed into a single sum.
- The sum is rounded, arithmetically right-shifted and saturated to WO bits.
- Sits directly downstream of the multiplier in the DPD datapath; its output drives the predistorted-sample register.

Parameters:
- WI, 20, width of signed input product
- WO, 20, width of signed output sample
- NMAX, 16, maximum product terms per sample (power of 2, >=2)
- SHIFT, 4, right-shift applied to the final sum (0..WI)

Ports:
- clk  input  1  clock
- reset_b  input  1  asynchronous reset, active-low
- clr  input  1  synchronous clear: drops any partial sum and clears err
- in_valid  input  1  in_data/in_last qualifier
- in_data  input  WI  signed product term
- in_last  input  1  marks the final term of the current sample
- out_valid  output  1  one-cycle pulse, out_data valid
- out_data  output  WO  signed rounded, saturated sum
- out_sat  output  1  saturation occurred on this out_valid beat
- err  output  1  sticky: frame exceeded NMAX terms
- term_cnt  output  $clog2(NMAX)+1  terms accepted in the current frame

Behaviour:
- Reset is asynchronous, active-low, with clock clk.
  - On reset every register clears: acc=0, term_cnt=0, first=1, out_valid=0, out_data=0, out_sat=0, err=0.
- Accumulator width WACC = WI + $clog2(NMAX) + 1. All arithmetic sign-extends in_data to WACC.
- Frame state is a two-state FSM:
  - IDLE (first=1), ACCUM (first=0).
  - IDLE -> ACCUM on in_valid & !in_last.
  - ACCUM -> IDLE on in_valid & in_last, or on forced dump.
  - A single-term frame (in_valid & in_last while IDLE) stays in IDLE and emits one output.
- Per accepted beat (in_valid=1):
  - sum_next = (first ? 0 : acc) + in_data.
  - If in_last=0 and no forced dump: acc <= sum_next, term_cnt increments.
- Output on a last beat (in_valid & in_last):
  - Cycle N+1 after that beat: out_valid=1 and out_data = sat(round(sum_next)).
  - The last beat's data is always included. Latency is 1 cycle.
  - acc is not required to hold its value; first<=1, term_cnt<=0.
- Rounding:
  - If SHIFT>0: r = (sum_next + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf.
  - If SHIFT=0: r = sum_next.
  - r is computed at WACC+1 bits so it cannot overflow.
- Saturation:
  - r > 2^(WO-1)-1 -> 2^(WO-1)-1.
  - r < -2^(WO-1) -> -2^(WO-1).
  - out_sat=1 on that beat only.
- Forced dump: occurs when a beat arrives with in_last=0 and term_cnt==NMAX-1, i.e. this would be the NMAX-th term.
  - The beat is treated as last: output is emitted, err<=1 (sticky), FSM returns to IDLE.
  - The next beat starts a new frame.
- Back-to-back frames: a new frame's first beat may arrive in the cycle right after a last beat. No bubble is required, and the old acc is never added into it.
- in_valid=0 cycles inside a frame: acc and term_cnt hold. There is no timeout.
- out_valid is deasserted in every cycle not directly following a last or forced-dump beat. out_data and out_sat hold their last values when out_valid=0.
- clr=1:
  - Next cycle: acc=0, term_cnt=0, first=1, err=0, out_valid=0.
  - clr overrides a concurrent in_valid beat, which is dropped.
- Reset mid-frame discards the partial sum. No output is produced for that frame.
- There is no backpressure. The downstream stage must accept every out_valid pulse.

Decomposition:
- Shared package dpd_pkg holds:
  - the WACC width function;
  - SAT_MAX/SAT_MIN constant functions of WO;
  - a round_shift_sat function (round, shift, saturate) shared with the other DPD stages.
- One natural sub-module, round_sat: a combinational round + shift + saturate taking WACC+1 bits to WO bits plus a sat flag. It is instantiated once at the output register input.

Test Plan:
- Single-term frame, SHIFT=4: in_data=40, last=1 -> next cycle out_valid=1, out_data=3 (40+8=48, >>4 = 3), out_sat=0, term_cnt back to 0.
- 4-term frame 100, -20, 7, 1 with gaps of idle cycles between beats -> sum 88, out_data=6 (96>>4), a single out_valid pulse one cycle after the last beat.
- Rounding of negatives, SHIFT=4: frame -24 -> out_data=-1 (-16>>>4). Frame -25 -> -2 (-17>>>4 = -2).
- Saturation, WI=20: 16 terms of 2^19-1 with last on the 16th -> r exceeds 2^19-1, so out_data=524287 and out_sat=1. The same test with -2^19 gives out_data=-524288 and out_sat=1.
- Overrun: 16 beats of value 16, none with last -> output after the 16th beat with out_data=16 and err=1. The 17th beat starts a new frame. err stays 1 until clr.
- Back-to-back frames {5, last} {3, last} on consecutive cycles with SHIFT=0 -> out_data 5 then 3 on consecutive cycles. Then clr asserted mid-frame -> no output, err=0.
